// File: rtl/mmix_defs.sv
// Shared MMIX definitions: access sizes, memory-bridge FSM states and size helpers.
package mmix_defs;

  typedef enum logic [1:0] {SZ_BYTE, SZ_WYDE, SZ_TETRA, SZ_OCTA} mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_DONE
  } bridge_state_t;

  // Number of 16-bit bus beats for one access.
  function automatic logic [2:0] size_beats(input mem_size_t size);
    case (size)
      SZ_TETRA: return 3'd2;
      SZ_OCTA:  return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  // Low byte-address bits cleared by MMIX alignment.
  function automatic logic [2:0] size_mask(input mem_size_t size);
    case (size)
      SZ_WYDE:  return 3'b001;
      SZ_TETRA: return 3'b011;
      SZ_OCTA:  return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mmix_mem_lane.sv
// Per-beat lane mapping: big-endian byte enables, write slice and word address.
module mmix_mem_lane
  import mmix_defs::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic [ADDR_W-1:0] addr,
  input  mem_size_t         size,
  input  logic [1:0]        beat,
  input  logic [63:0]       wdata,
  output logic [1:0]        byteenable,
  output logic [15:0]       writedata,
  output logic [ADDR_W-2:0] word_addr
);

  logic [1:0] wyde_idx;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    byteenable = 2'b11;
    writedata  = 16'h0000;
    wyde_idx   = 2'(size_beats(size) - 3'd1) - beat;
    // addr is aligned, so OR-ing the beat index never carries out of the block.
    word_addr  = addr[ADDR_W-1:1] | {{(ADDR_W-3){1'b0}}, beat};
    if (size == SZ_BYTE) begin
      byteenable = addr[0] ? 2'b01 : 2'b10;
      writedata  = {wdata[7:0], wdata[7:0]};
    end else begin
      // First beat carries the most significant wyde.
      writedata = wdata[{wyde_idx, 4'b0000} +: 16];
    end
  end

endmodule

// File: rtl/mmix_mem_bridge.sv
// MMIX load/store to 16-bit Avalon-MM master bridge: splits each access into
// 1-4 big-endian beats and returns zero-extended, right-justified load data.
module mmix_mem_bridge
  import mmix_defs::*;
#(
  parameter int ADDR_W    = 23,
  parameter bit PIPELINED = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic [ADDR_W-2:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [1:0]        av_byteenable,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              av_readdatavalid,
  input  logic              av_waitrequest
);

  bridge_state_t     state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_aligned;
  mem_size_t         size_q, size_in;
  logic [63:0]       wdata_q, acc;
  logic [2:0]        issued, received, beats;
  logic              issue_ok, beat_acc, last_issue, rx_valid, last_rx;
  logic [1:0]        lane_be;
  logic [15:0]       lane_wd;
  logic [ADDR_W-2:0] lane_addr;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^mem_address[63:ADDR_W];
  assign size_in        = mem_size_t'(mem_datasize);
  assign addr_aligned   = mem_address[ADDR_W-1:0] & ~ADDR_W'(size_mask(size_in));

  assign beats      = size_beats(size_q);
  // Non-pipelined mode issues only when every issued beat has returned.
  assign issue_ok   = PIPELINED ? 1'b1 : (issued == received);
  assign beat_acc   = (av_read | av_write) & ~av_waitrequest;
  assign last_issue = (issued == beats - 3'd1);
  assign rx_valid   = av_readdatavalid & (state == ST_RD_ISSUE || state == ST_RD_WAIT);
  assign last_rx    = rx_valid & (received == beats - 3'd1);

  mmix_mem_lane #(.ADDR_W(ADDR_W)) u_lane (
    .addr       (addr_q),
    .size       (size_q),
    .beat       (issued[1:0]),
    .wdata      (wdata_q),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .word_addr  (lane_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (mem_write)     state_nx = ST_WR_ISSUE;
        else if (mem_read) state_nx = ST_RD_ISSUE;
      end
      ST_WR_ISSUE: if (beat_acc && last_issue) state_nx = ST_DONE;
      ST_RD_ISSUE: begin
        if (last_rx)                     state_nx = ST_DONE;
        else if (beat_acc && last_issue) state_nx = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (last_rx) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    av_write      = (state == ST_WR_ISSUE);
    av_read       = (state == ST_RD_ISSUE) && issue_ok;
    av_address    = (av_read || av_write) ? lane_addr : '0;
    av_byteenable = (av_read || av_write) ? lane_be : 2'b00;
    av_writedata  = av_write ? lane_wd : 16'h0000;
    mem_done      = (state == ST_DONE);
  end

  // NOTE: the accumulator and captured request are plain registers, so they take the async reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      wdata_q      <= '0;
      acc          <= '0;
      issued       <= '0;
      received     <= '0;
      mem_readdata <= '0;
    end else begin
      if (state == ST_IDLE && (mem_read || mem_write)) begin
        addr_q   <= addr_aligned;
        size_q   <= size_in;
        wdata_q  <= mem_writedata;
        acc      <= '0;
        issued   <= '0;
        received <= '0;
      end else begin
        if (beat_acc) issued <= issued + 3'd1;
        if (rx_valid) begin
          received <= received + 3'd1;
          acc      <= {acc[47:0], av_readdata};
        end
        if (last_rx) begin
          if (size_q == SZ_BYTE)
            mem_readdata <= {56'h0, addr_q[0] ? av_readdata[7:0] : av_readdata[15:8]};
          else
            mem_readdata <= {acc[47:0], av_readdata};
        end
      end
    end
  end

endmodule

// File: doc/mmix_mem_bridge.md
Name: mmix_mem_bridge

Overview:
- Downstream of exec_unit's memory port: accepts one load/store per handshake (byte/wyde/tetra/octa, big-endian MMIX semantics).
- Converts each request into 1–4 beats on a 16-bit Avalon-MM master toward the DE0 SDRAM controller.
- Returns zero-extended, right-justified load data with a one-cycle mem_done.
- Sign extension and other exec semantics stay in exec_unit.

Parameters:
- ADDR_W, 23: byte-address width of the physical memory. mem_address bits above ADDR_W-1 are ignored.
- PIPELINED, 1: 1 = issue all read beats back-to-back. 0 = at most one read outstanding.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_address  in  64  byte address from exec_unit
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_writedata  in  64  store data, right-justified
- mem_readdata  out  64  load data, zero-extended
- mem_done  out  1  one-cycle completion pulse
- av_address  out  ADDR_W-1  wyde (word) address
- av_read  out  1  Avalon read
- av_write  out  1  Avalon write
- av_byteenable  out  2  [1] = even byte, [0] = odd byte
- av_writedata  out  16  [15:8] = even-address byte
- av_readdata  in  16  read beat data
- av_readdatavalid  in  1  read beat valid
- av_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, immediate): state IDLE; av_read=0, av_write=0, av_byteenable=0, av_address=0, av_writedata=0, mem_done=0, mem_readdata=0; beat counters cleared.
- Request acceptance:
  - Sampled in IDLE on a clk edge with mem_read|mem_write high.
  - address, size and writedata are captured; exec_unit inputs may change afterwards.
  - Both mem_read and mem_write high: store performed, read ignored.
  - Requests seen outside IDLE/DONE are ignored.
- Alignment: effective address = mem_address with the low log2(bytes) bits cleared (MMIX rule).
  - Beats = max(1, bytes/2).
  - Beats go in ascending address order; the first beat carries the most significant wyde.
- Byte lanes (big-endian): byte at even address ↔ bit [15:8] / byteenable[1]; odd address ↔ [7:0] / byteenable[0]. Wyde/tetra/octa beats use byteenable=2'b11.
- State machine: IDLE → RD_ISSUE or WR_ISSUE → (RD_WAIT) → DONE → IDLE.
  - WR_ISSUE:
    - av_write held with address/data stable while av_waitrequest=1.
    - A beat is accepted on an edge with av_waitrequest=0; then advance to the next beat.
    - After the last beat is accepted → DONE.
  - RD_ISSUE:
    - av_read asserted; beat accepted when av_waitrequest=0.
    - PIPELINED=1: next beat address presented the following cycle; after the last accepted beat → RD_WAIT.
    - PIPELINED=0: after each accepted beat wait for its readdatavalid before issuing the next.
  - Read data collection:
    - av_readdatavalid counted in RD_ISSUE and RD_WAIT.
    - Each valid beat shifts into an accumulator (acc = {acc[47:0], av_readdata}).
    - Byte loads select [15:8] or [7:0] by address bit 0.
    - When all beats are received → DONE.
  - DONE: mem_done=1 for exactly one cycle; mem_readdata updated in that same cycle and held until the next load completes. Stores leave mem_readdata unchanged. → IDLE.
- Latency: minimum request-to-done with zero wait states and single-cycle read latency:
  - byte/wyde store: 2 cycles; octa store: 5 cycles.
  - octa read (pipelined): 6 cycles.
- av_readdatavalid in IDLE/DONE (stale data from a reset-interrupted read) is ignored.
- Reset mid-operation: the bus request drops asynchronously. No mem_done is produced for the aborted request.
- Address wrap: the beat address increments within the aligned block only; it never carries past the octa boundary.

Decomposition:
- Shared package mmix_defs gains:
  - typedef enum logic[1:0] mem_size_t {SZ_BYTE, SZ_WYDE, SZ_TETRA, SZ_OCTA};
  - the bridge state enum;
  - function size_beats(mem_size_t).
- One natural sub-module: mmix_mem_lane, combinational. Per beat index it produces byteenable, the writedata slice and the aligned word address. The FSM, counters and accumulator stay in mmix_mem_bridge.

Test Plan:
- Octa load, mem_address=0x13, memory wydes @0x10..0x16 = 0x2000,0x0000,0x0000,0xFFFF, no waits → av_address 0x8,0x9,0xA,0xB back-to-back; mem_readdata=0x200000000000ffff; mem_done one cycle.
- Byte store 0xAB to 0x1235 → single av_write, av_address=0x91A, byteenable=2'b01, writedata[7:0]=0xAB.
- Byte store 0xCD to 0x1234 → byteenable=2'b10, writedata[15:8]=0xCD.
- Tetra load @0x20 with av_waitrequest=1 for 3 cycles on beat 0 → av_address/av_read stable during the stall; mem_readdata={32'b0, wyde@0x20, wyde@0x22}; no early mem_done.
- reset_n low during octa load after 2 beats, then a late av_readdatavalid → outputs at reset values immediately; no mem_done; the next wyde load @0x40 returns correct data.
- Simultaneous mem_read=1, mem_write=1 on a tetra @0x8 → only av_write beats (2); mem_readdata unchanged; one mem_done.
- PIPELINED=0 octa load with 3-cycle read latency → each av_read waits for the prior readdatavalid; final data identical to the pipelined result.
